// File: rtl/trace_checker_pkg.sv
// -----------------------------------------------------------------------------
// trace_checker_pkg
// Shared definitions for the trace checker:
//   state_t    - checker state (IDLE / RUN / PASS / FAIL)
//   ERR_*      - err_code values reported on failure
// -----------------------------------------------------------------------------
package trace_checker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PASS = 2'd2,
    ST_FAIL = 2'd3
  } state_t;

  localparam logic [2:0] ERR_NONE    = 3'd0;
  localparam logic [2:0] ERR_ADDR    = 3'd1;
  localparam logic [2:0] ERR_DATA    = 3'd2;
  localparam logic [2:0] ERR_TIMEOUT = 3'd3;
  localparam logic [2:0] ERR_EXTRA   = 3'd4;

endpackage

// File: rtl/trace_fifo.sv
// -----------------------------------------------------------------------------
// trace_fifo
// Synchronous FIFO holding expected trace records. Head is read
// combinationally so the checker can compare a beat in the cycle it arrives.
// Ports:
//   clk, rst     - clock, asynchronous active-low reset
//   clr_i        - synchronous flush (pointers and count to zero)
//   push_i       - write wdata_i at tail (ignored when full)
//   pop_i        - drop head record (ignored when empty)
//   wdata_i      - record to write
//   rdata_o      - head record
//   rd_idx_o     - head index (read pointer)
//   full_o, empty_o, count_o - occupancy status, count in 0..DEPTH
// -----------------------------------------------------------------------------
module trace_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 65
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [WIDTH-1:0]           wdata_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic [$clog2(DEPTH)-1:0]   rd_idx_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [IDX_W-1:0] PTR_ONE = 1;
  localparam logic [IDX_W:0]   CNT_ONE = 1;
  localparam logic [IDX_W:0]   CNT_MAX = DEPTH;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [IDX_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [IDX_W:0]   count_q;
  logic             do_push, do_pop;

  assign full_o   = (count_q == CNT_MAX);
  assign empty_o  = (count_q == '0);
  assign do_push  = push_i && !full_o && !clr_i;
  assign do_pop   = pop_i && !empty_o && !clr_i;
  assign rdata_o  = mem_q[rd_ptr_q];
  assign rd_idx_o = rd_ptr_q;
  assign count_o  = count_q;

  // Storage carries no reset so it maps onto distributed RAM.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/trace_checker.sv
// -----------------------------------------------------------------------------
// trace_checker
// Buffers expected (addr, data) trace records, then checks processor trace
// beats against them in order. Latches the first address/data mismatch,
// stall timeout or surplus beat together with the offending beat.
// Ports:
//   clk, rst                         - clock, asynchronous active-low reset
//   load_val/load_rdy/load_addr/load_data/load_dcare - expected record load
//   start, clear                     - begin checking / flush to IDLE
//   trace_val/trace_addr/trace_data  - processor trace beat
//   busy, done, pass, fail           - status decoded from the state register
//   err_code/err_index/err_addr/err_data - failure details (frozen in FAIL)
//   matched                          - records matched so far
// -----------------------------------------------------------------------------
module trace_checker
  import trace_checker_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load_val,
  output logic                      load_rdy,
  input  logic [ADDR_W-1:0]         load_addr,
  input  logic [DATA_W-1:0]         load_data,
  input  logic                      load_dcare,
  input  logic                      start,
  input  logic                      clear,
  input  logic                      trace_val,
  input  logic [ADDR_W-1:0]         trace_addr,
  input  logic [DATA_W-1:0]         trace_data,
  output logic                      busy,
  output logic                      done,
  output logic                      pass,
  output logic                      fail,
  output logic [2:0]                err_code,
  output logic [$clog2(DEPTH)-1:0]  err_index,
  output logic [ADDR_W-1:0]         err_addr,
  output logic [DATA_W-1:0]         err_data,
  output logic [$clog2(DEPTH):0]    matched
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int TMR_W = $clog2(TIMEOUT + 1);
  localparam int REC_W = ADDR_W + DATA_W + 1;
  localparam logic [TMR_W-1:0] TMR_ONE  = 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic [IDX_W:0]   CNT_ONE  = 1;

  state_t              state_q, state_d;
  logic [2:0]          err_code_q, err_code_d;
  logic [IDX_W-1:0]    err_index_q, err_index_d;
  logic [ADDR_W-1:0]   err_addr_q, err_addr_d;
  logic [DATA_W-1:0]   err_data_q, err_data_d;
  logic [IDX_W:0]      matched_q, matched_d;
  logic [TMR_W-1:0]    timer_q, timer_d;

  logic                fifo_clr, fifo_push, fifo_pop;
  logic                fifo_full, fifo_empty;
  logic [IDX_W:0]      fifo_count;
  logic [IDX_W-1:0]    head_idx;
  logic [REC_W-1:0]    head_rec, load_rec;
  logic                head_dcare;
  logic [ADDR_W-1:0]   head_addr;
  logic [DATA_W-1:0]   head_data;

  // Record layout: {dcare, addr, data}
  assign load_rec   = {load_dcare, load_addr, load_data};
  assign head_dcare = head_rec[REC_W-1];
  assign head_addr  = head_rec[ADDR_W+DATA_W-1:DATA_W];
  assign head_data  = head_rec[DATA_W-1:0];

  trace_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (REC_W)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (fifo_clr),
    .push_i   (fifo_push),
    .pop_i    (fifo_pop),
    .wdata_i  (load_rec),
    .rdata_o  (head_rec),
    .rd_idx_o (head_idx),
    .full_o   (fifo_full),
    .empty_o  (fifo_empty),
    .count_o  (fifo_count)
  );

  always_comb begin
    state_d     = state_q;
    err_code_d  = err_code_q;
    err_index_d = err_index_q;
    err_addr_d  = err_addr_q;
    err_data_d  = err_data_q;
    matched_d   = matched_q;
    timer_d     = timer_q;
    fifo_clr    = 1'b0;
    fifo_push   = 1'b0;
    fifo_pop    = 1'b0;

    if (clear) begin
      state_d     = ST_IDLE;
      err_code_d  = ERR_NONE;
      err_index_d = '0;
      err_addr_d  = '0;
      err_data_d  = '0;
      matched_d   = '0;
      timer_d     = '0;
      fifo_clr    = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          fifo_push = load_val && !fifo_full;
          if (start) begin
            timer_d = '0;
            // A record loaded alongside start still counts as non-empty.
            state_d = (fifo_empty && !fifo_push) ? ST_PASS : ST_RUN;
          end
        end
        ST_RUN: begin
          if (fifo_empty) begin
            state_d = ST_PASS;
          end else if (trace_val) begin
            if (trace_addr != head_addr) begin
              state_d     = ST_FAIL;
              err_code_d  = ERR_ADDR;
              err_index_d = head_idx;
              err_addr_d  = trace_addr;
              err_data_d  = trace_data;
            end else if (!head_dcare && (trace_data != head_data)) begin
              state_d     = ST_FAIL;
              err_code_d  = ERR_DATA;
              err_index_d = head_idx;
              err_addr_d  = trace_addr;
              err_data_d  = trace_data;
            end else begin
              fifo_pop  = 1'b1;
              matched_d = matched_q + CNT_ONE;
              timer_d   = '0;
              if (fifo_count == CNT_ONE) state_d = ST_PASS;
            end
          end else if (timer_q == TMR_LAST) begin
            // This beatless cycle is the TIMEOUT-th one since the last beat.
            state_d     = ST_FAIL;
            err_code_d  = ERR_TIMEOUT;
            err_index_d = head_idx;
            err_addr_d  = '0;
            err_data_d  = '0;
          end else begin
            timer_d = timer_q + TMR_ONE;
          end
        end
        ST_PASS: begin
          if (trace_val) begin
            state_d     = ST_FAIL;
            err_code_d  = ERR_EXTRA;
            err_index_d = matched_q[IDX_W-1:0];
            err_addr_d  = trace_addr;
            err_data_d  = trace_data;
          end
        end
        default: ; // FAIL is sticky until clear
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      err_code_q  <= ERR_NONE;
      err_index_q <= '0;
      err_addr_q  <= '0;
      err_data_q  <= '0;
      matched_q   <= '0;
      timer_q     <= '0;
    end else begin
      state_q     <= state_d;
      err_code_q  <= err_code_d;
      err_index_q <= err_index_d;
      err_addr_q  <= err_addr_d;
      err_data_q  <= err_data_d;
      matched_q   <= matched_d;
      timer_q     <= timer_d;
    end
  end

  assign load_rdy  = (state_q == ST_IDLE) && !fifo_full;
  assign busy      = (state_q == ST_RUN);
  assign pass      = (state_q == ST_PASS);
  assign fail      = (state_q == ST_FAIL);
  assign done      = pass || fail;
  assign err_code  = err_code_q;
  assign err_index = err_index_q;
  assign err_addr  = err_addr_q;
  assign err_data  = err_data_q;
  assign matched   = matched_q;

endmodule

// File: tb/tb_trace_checker.sv
// -----------------------------------------------------------------------------
// tb_trace_checker
// Directed and randomized checks of trace_checker against a queue-based
// reference model of the expected-record list.
// -----------------------------------------------------------------------------
module tb_trace_checker;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int TMO   = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          load_val = 1'b0;
  logic          load_rdy;
  logic [AW-1:0] load_addr = '0;
  logic [DW-1:0] load_data = '0;
  logic          load_dcare = 1'b0;
  logic          start = 1'b0;
  logic          clear = 1'b0;
  logic          trace_val = 1'b0;
  logic [AW-1:0] trace_addr = '0;
  logic [DW-1:0] trace_data = '0;
  logic          busy, done, pass, fail;
  logic [2:0]    err_code;
  logic [3:0]    err_index;
  logic [AW-1:0] err_addr;
  logic [DW-1:0] err_data;
  logic [4:0]    matched;

  always #5 clk = ~clk;

  trace_checker #(
    .ADDR_W (AW),
    .DATA_W (DW),
    .DEPTH  (DEPTH),
    .TIMEOUT(TMO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .load_val   (load_val),
    .load_rdy   (load_rdy),
    .load_addr  (load_addr),
    .load_data  (load_data),
    .load_dcare (load_dcare),
    .start      (start),
    .clear      (clear),
    .trace_val  (trace_val),
    .trace_addr (trace_addr),
    .trace_data (trace_data),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .fail       (fail),
    .err_code   (err_code),
    .err_index  (err_index),
    .err_addr   (err_addr),
    .err_data   (err_data),
    .matched    (matched)
  );

  // ---------------- reference model ----------------
  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic          dc;
  } rec_t;

  rec_t          mq[$];      // records still expected, in load order
  int            mst;        // 0 idle, 1 running, 2 passed, 3 failed
  int            m_matched;
  int            m_idle;     // beatless cycles since last accepted beat
  int            m_code;
  int            m_index;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;

  int vectors     = 0;
  int miscompares = 0;

  task automatic model_reset();
    mq.delete();
    mst = 0; m_matched = 0; m_idle = 0;
    m_code = 0; m_index = 0; m_addr = '0; m_data = '0;
  endtask

  task automatic model_fail(input int code, input logic [AW-1:0] a, input logic [DW-1:0] d);
    mst = 3; m_code = code; m_index = m_matched % DEPTH; m_addr = a; m_data = d;
  endtask

  // Applies the inputs present for the coming clock edge to the model.
  task automatic model_step();
    rec_t r;
    if (clear) begin
      model_reset();
    end else begin
      case (mst)
        0: begin
          if (load_val && mq.size() < DEPTH) begin
            r.a = load_addr; r.d = load_data; r.dc = load_dcare;
            mq.push_back(r);
          end
          if (start) begin
            mst = (mq.size() == 0) ? 2 : 1;
            m_idle = 0;
          end
        end
        1: begin
          if (trace_val) begin
            r = mq[0];
            if (trace_addr !== r.a) model_fail(1, trace_addr, trace_data);
            else if (!r.dc && trace_data !== r.d) model_fail(2, trace_addr, trace_data);
            else begin
              mq.delete(0);
              m_matched++;
              m_idle = 0;
              if (mq.size() == 0) mst = 2;
            end
          end else begin
            m_idle++;
            if (m_idle == TMO) model_fail(3, '0, '0);
          end
        end
        2: if (trace_val) model_fail(4, trace_addr, trace_data);
        default: ;
      endcase
    end
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    chk({tag, ".busy"},      busy,      mst == 1);
    chk({tag, ".done"},      done,      mst >= 2);
    chk({tag, ".pass"},      pass,      mst == 2);
    chk({tag, ".fail"},      fail,      mst == 3);
    chk({tag, ".load_rdy"},  load_rdy,  (mst == 0) && (mq.size() < DEPTH));
    chk({tag, ".err_code"},  err_code,  m_code);
    chk({tag, ".err_index"}, err_index, m_index);
    chk({tag, ".err_addr"},  err_addr,  m_addr);
    chk({tag, ".err_data"},  err_data,  m_data);
    chk({tag, ".matched"},   matched,   m_matched);
  endtask

  task automatic cycle(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check_state(tag);
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic load(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic dc);
    $display("load  a=%h d=%h dcare=%0d rdy=%0d", a, d, dc, load_rdy);
    load_val = 1'b1; load_addr = a; load_data = d; load_dcare = dc;
    cycle("load");
    load_val = 1'b0;
  endtask

  task automatic beat(input logic [AW-1:0] a, input logic [DW-1:0] d);
    trace_val = 1'b1; trace_addr = a; trace_data = d;
    cycle("beat");
    trace_val = 1'b0;
    $display("beat  a=%h d=%h -> pass=%0d fail=%0d code=%0d matched=%0d",
             a, d, pass, fail, err_code, matched);
  endtask

  task automatic pulse_start();
    $display("start");
    start = 1'b1;
    cycle("start");
    start = 1'b0;
  endtask

  task automatic pulse_clear();
    $display("clear");
    clear = 1'b1;
    cycle("clear");
    clear = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle("idle");
  endtask

  task automatic load_three();
    load(32'h1, 32'h3, 1'b0);
    load(32'h2, 32'hFFFF_FFFE, 1'b0);
    load(32'h3, 32'h7FF, 1'b0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    rec_t exp_list[$];
    int   n, gap, mode;
    logic [AW-1:0] a;
    logic [DW-1:0] d;

    model_reset();

    // Reset state while rst is held low
    #3;
    check_state("reset");
    @(posedge clk); #1;
    rst = 1'b1;
    idle(1);

    // Test 1: three matching beats
    load_three();
    pulse_start();
    beat(32'h1, 32'h3);
    beat(32'h2, 32'hFFFF_FFFE);
    chk("t1.pass_early", pass, 1'b0);
    beat(32'h3, 32'h7FF);
    chk("t1.pass", pass, 1'b1);
    chk("t1.matched", matched, 3);
    chk("t1.err_code", err_code, 0);
    pulse_clear();

    // Test 2: data mismatch on the second record
    load_three();
    pulse_start();
    beat(32'h1, 32'h3);
    beat(32'h2, 32'hFFFF_FFFF);
    chk("t2.fail", fail, 1'b1);
    chk("t2.err_code", err_code, 2);
    chk("t2.err_index", err_index, 1);
    chk("t2.err_data", err_data, 32'hFFFF_FFFF);
    beat(32'h3, 32'h7FF);
    chk("t2.fail_sticky", fail, 1'b1);
    pulse_clear();

    // Test 3: don't-care data, then a surplus beat
    load(32'h5, 32'h0, 1'b1);
    pulse_start();
    beat(32'h5, 32'hDEAD_BEEF);
    chk("t3.pass", pass, 1'b1);
    beat(32'h6, 32'h1);
    chk("t3.fail", fail, 1'b1);
    chk("t3.err_code", err_code, 4);
    chk("t3.err_addr", err_addr, 32'h6);
    pulse_clear();

    // Test 4: stall timeout after one matching beat
    load(32'h10, 32'h20, 1'b0);
    load(32'h11, 32'h21, 1'b0);
    pulse_start();
    beat(32'h10, 32'h20);
    idle(TMO - 1);
    chk("t4.fail_early", fail, 1'b0);
    idle(1);
    chk("t4.fail", fail, 1'b1);
    chk("t4.err_code", err_code, 3);
    chk("t4.err_index", err_index, 1);
    pulse_clear();

    // Test 5: fill to DEPTH, surplus load ignored, match all
    for (int i = 0; i < DEPTH; i++) load($urandom, $urandom, 1'b0);
    chk("t5.load_rdy_full", load_rdy, 1'b0);
    load(32'hAAAA_AAAA, 32'h5555_5555, 1'b0);
    exp_list = mq;
    pulse_start();
    foreach (exp_list[i]) beat(exp_list[i].a, exp_list[i].d);
    chk("t5.pass", pass, 1'b1);
    chk("t5.matched", matched, DEPTH);
    pulse_clear();
    chk("t5.load_rdy_clr", load_rdy, 1'b1);
    chk("t5.matched_clr", matched, 0);

    // Test 6: start with nothing loaded
    pulse_start();
    chk("t6.pass_empty", pass, 1'b1);
    pulse_clear();

    // Test 7: asynchronous reset in the middle of a run
    load_three();
    pulse_start();
    beat(32'h1, 32'h3);
    beat(32'h2, 32'hFFFF_FFFE);
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check_state("async_rst");
    chk("t7.load_rdy", load_rdy, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    load(32'h7, 32'h8, 1'b0);
    load(32'h9, 32'hA, 1'b0);
    pulse_start();
    beat(32'h7, 32'h8);
    beat(32'h9, 32'hA);
    chk("t7.pass", pass, 1'b1);
    pulse_clear();

    // Randomized runs: random records, gaps, corruptions and surplus beats
    for (int it = 0; it < 24; it++) begin
      n = $urandom_range(1, DEPTH);
      for (int i = 0; i < n; i++) load($urandom, $urandom, ($urandom_range(0, 3) == 0));
      exp_list = mq;
      pulse_start();
      foreach (exp_list[i]) begin
        if (mst != 1) break;
        gap = ($urandom_range(0, 7) == 0) ? $urandom_range(0, TMO + 1) : 0;
        idle(gap);
        if (mst != 1) break;
        a = exp_list[i].a;
        d = exp_list[i].d;
        mode = $urandom_range(0, 11);
        if (mode == 0) a = a ^ (32'h1 << $urandom_range(0, AW - 1));
        if (mode == 1) d = d ^ (32'h1 << $urandom_range(0, DW - 1));
        beat(a, d);
      end
      if ($urandom_range(0, 1) == 1) beat($urandom, $urandom);
      idle(2);
      pulse_clear();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/trace_checker.md
Name: trace_checker

Overview:
Synthesizable self-checking monitor for processor test harnesses. Buffers an expected sequence of (addr, data) trace records, then compares each processor trace beat (trace_val/trace_addr/trace_data) in order against it. Flags the first mismatch, stall timeout or surplus beat, and captures the offending beat. Sits beside the processor and test memory so directed tests run without testbench-side polling.

Parameters:
ADDR_W, 32, trace address width
DATA_W, 32, trace data width
DEPTH, 16, expected-record buffer entries (power of 2, >=2)
TIMEOUT, 64, max cycles between accepted trace beats while records remain (>=1)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
load_val  in  1  expected record valid
load_rdy  out  1  record accepted when load_val & load_rdy
load_addr  in  ADDR_W  expected trace address
load_data  in  DATA_W  expected trace data
load_dcare  in  1  1 = ignore data compare for this record
start  in  1  begin checking (pulse)
clear  in  1  flush buffer, return to IDLE (pulse)
trace_val  in  1  processor trace beat valid
trace_addr  in  ADDR_W  processor trace address
trace_data  in  DATA_W  processor trace data
busy  out  1  state == RUN
done  out  1  state is PASS or FAIL
pass  out  1  state == PASS
fail  out  1  state == FAIL
err_code  out  3  0 none, 1 addr mismatch, 2 data mismatch, 3 timeout, 4 extra beat
err_index  out  $clog2(DEPTH)  index of failing record (0-based load order)
err_addr  out  ADDR_W  trace_addr captured on failure
err_data  out  DATA_W  trace_data captured on failure
matched  out  $clog2(DEPTH)+1  records matched so far

Behaviour:
- Reset (rst=0, async): state IDLE, buffer empty, all outputs 0 except load_rdy=1.
- States: IDLE, RUN, PASS, FAIL. The clear pulse in any state enters IDLE next cycle, empties the buffer, and zeroes err_*, matched and the timer. clear has priority over every other event.
- IDLE: load_rdy = !full. A loaded record is written at the tail; count increments. When the buffer is full, load_rdy=0 and load_val is ignored. start -> RUN; if load and start are in the same cycle, the record is kept. trace_val is ignored in IDLE.
- RUN: load_rdy=0. Each trace_val compares against the head record, and the result is registered at the next edge:
  - addr differs -> FAIL, code 1 (the addr check takes precedence over the data check);
  - else if !dcare and data differs -> FAIL, code 2;
  - else pop the head, increment matched, clear the timer.
  - When the last record matches, the state becomes PASS on the same edge. Start with an empty buffer -> PASS on the next cycle.
- Timer: counts cycles in RUN without a trace beat. When it reaches TIMEOUT -> FAIL, code 3, err_addr/err_data = 0, err_index = head index.
- PASS: any trace_val -> FAIL, code 4, err_index = matched mod DEPTH, beat captured. This latches the over-run.
- FAIL: sticky until clear; further trace beats are ignored and err_* are frozen.
- A start pulse in RUN, PASS or FAIL has no effect.
- Pointers wrap modulo DEPTH. Count ranges 0..DEPTH.
- Outputs are registered: done/pass/fail assert the cycle after the deciding beat, with latency 1.

Decomposition:
- Package trace_checker_pkg: state enum (IDLE/RUN/PASS/FAIL), err_code constants (ERR_NONE..ERR_EXTRA).
- Sub-module trace_fifo: parametrised synchronous FIFO (DEPTH, width ADDR_W+DATA_W+1) with push/pop/full/empty/count and the same async active-low rst.

Test Plan:
- Load (0x01,0x3),(0x02,0xFFFFFFFE),(0x03,0x7FF) with dcare=0; start; drive the matching beats on consecutive cycles -> pass=1 one cycle after the third beat, matched=3, err_code=0.
- Same load; second beat data 0xFFFFFFFF -> fail=1, err_code=2, err_index=1, err_data=0xFFFFFFFF; a later correct beat leaves fail=1.
- Load one record (0x05,0x0) with dcare=1; beat (0x05,0xDEADBEEF) -> pass; a further beat (0x06,0x1) -> fail, err_code=4, err_addr=0x6.
- TIMEOUT=8: load 2 records, start, give one matching beat, then idle -> fail exactly 8 cycles after the last beat, err_code=3, err_index=1.
- Load DEPTH=16 records -> load_rdy=0 after the 16th; a 17th load_val is ignored. Start and match all 16 -> pass, matched=16. clear -> IDLE, load_rdy=1, matched=0.
- Assert rst low mid-RUN after 2 matches -> all outputs 0 and load_rdy=1 immediately (async). Then reload and run -> pass.
